// File: rtl/cordic_pkg.sv
// cordic_pkg: FSM states, binary-angle constants and atan table generation shared by the CORDIC cores
package cordic_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ROTATE = 2'd1, DONE = 2'd2} state_e;
  function automatic int angle_pi(input int zw);
    return 1 << (zw - 1);
  endfunction
  function automatic int angle_pi_half(input int zw);
    return 1 << (zw - 2);
  endfunction
  function automatic int atan_entry(input int i, input int frac);
    real a;
    a = $atan(2.0 ** (-i)) * (2.0 ** frac) / 3.14159265358979323846;
    return $rtoi(a + 0.5);
  endfunction
endpackage

// File: rtl/cordic_atan_lut.sv
// cordic_atan_lut: combinational iteration index to rounded binary-angle atan(2^-i)
module cordic_atan_lut
  import cordic_pkg::*;
#(
  parameter int ZW = 10,
  parameter int ITERATIONS = 7,
  parameter int IW = 4
) (
  input  logic [IW-1:0] iter_i,
  output logic [ZW-1:0] atan_o
);
  logic [ZW-1:0] tbl [ITERATIONS];
  for (genvar k = 0; k < ITERATIONS; k++) begin : g_tbl
    localparam logic [ZW-1:0] A = ZW'(atan_entry(k, ZW - 1));
    assign tbl[k] = A;
  end
  always_comb begin
    atan_o = '0;
    for (int i = 0; i < ITERATIONS; i++) atan_o = (iter_i == IW'(i)) ? tbl[i] : atan_o;
  end
endmodule

// File: rtl/cordic_vectoring_iterative.sv
// cordic_vectoring_iterative: iterative vectoring CORDIC returning gain-scaled magnitude and atan2(y, x)
module cordic_vectoring_iterative
  import cordic_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ITERATIONS = 7,
  parameter int GUARD_BITS = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] x_i,
  input  logic [DATA_WIDTH-1:0] y_i,
  input  logic                  data_in_valid_strobe_i,
  output logic [DATA_WIDTH:0]   mag_o,
  output logic [DATA_WIDTH-1:0] z_o,
  output logic                  data_out_valid_strobe_o,
  output logic                  busy_o
);
  localparam int W = DATA_WIDTH + 2 + GUARD_BITS;
  localparam int ZW = DATA_WIDTH + GUARD_BITS;
  localparam int MW = DATA_WIDTH + 1;
  localparam int IW = $clog2(ITERATIONS) + 1;
  localparam logic signed [ZW-1:0] PH = ZW'(angle_pi_half(ZW));
  localparam logic signed [W-1:0] XH = W'(2 ** (GUARD_BITS - 1));
  localparam logic signed [ZW-1:0] ZH = ZW'(2 ** (GUARD_BITS - 1));
  state_e state_q, state_d;
  logic signed [W-1:0] x_q, x_d, y_q, y_d, xe, ye, xr, yr;
  logic signed [ZW-1:0] z_q, z_d, zr, atan;
  logic [IW-1:0] iter_q, iter_d;
  logic [MW-1:0] mag_q, mag_d;
  logic [DATA_WIDTH-1:0] zo_q, zo_d;
  logic vld_q, vld_d, busy_q, busy_d, d, xn, yn;
  cordic_atan_lut #(.ZW(ZW), .ITERATIONS(ITERATIONS), .IW(IW)) u_lut (
    .iter_i(iter_q),
    .atan_o(atan)
  );
  always_comb begin
    xn = x_i[DATA_WIDTH-1];
    yn = y_i[DATA_WIDTH-1];
    xe = {{2{xn}}, x_i, {GUARD_BITS{1'b0}}};
    ye = {{2{yn}}, y_i, {GUARD_BITS{1'b0}}};
    d = !y_q[W-1];
    xr = d ? x_q + (y_q >>> iter_q) : x_q - (y_q >>> iter_q);
    yr = d ? y_q - (x_q >>> iter_q) : y_q + (x_q >>> iter_q);
    zr = d ? z_q + atan : z_q - atan;
    state_d = state_q;
    x_d = x_q;
    y_d = y_q;
    z_d = z_q;
    iter_d = iter_q;
    mag_d = mag_q;
    zo_d = zo_q;
    vld_d = 1'b0;
    busy_d = busy_q;
    if (state_q == IDLE && data_in_valid_strobe_i) begin
      state_d = ROTATE;
      busy_d = 1'b1;
      iter_d = '0;
      x_d = !xn ? xe : !yn ? ye : -ye;
      y_d = !xn ? ye : !yn ? -xe : xe;
      z_d = !xn ? '0 : !yn ? PH : -PH;
    end else if (state_q == ROTATE) begin
      x_d = xr;
      y_d = yr;
      z_d = zr;
      iter_d = iter_q + IW'(1);
      if (iter_q == IW'(ITERATIONS - 1)) begin
        state_d = DONE;
        vld_d = 1'b1;
        mag_d = MW'((xr + XH) >>> GUARD_BITS);
        zo_d = DATA_WIDTH'((zr + ZH) >>> GUARD_BITS);
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
      busy_d = 1'b0;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
      iter_q <= '0;
      mag_q <= '0;
      zo_q <= '0;
      vld_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      z_q <= z_d;
      iter_q <= iter_d;
      mag_q <= mag_d;
      zo_q <= zo_d;
      vld_q <= vld_d;
      busy_q <= busy_d;
    end
  end
  assign mag_o = mag_q;
  assign z_o = zo_q;
  assign data_out_valid_strobe_o = vld_q;
  assign busy_o = busy_q;
endmodule

// File: tb/tb_cordic_vectoring_iterative.sv
// tb_cordic_vectoring_iterative: randomized and directed checks against an integer CORDIC vectoring model
module tb_cordic_vectoring_iterative;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stb = 1'b0;
  logic [7:0] x = '0;
  logic [7:0] y = '0;
  logic [8:0] mag;
  logic [7:0] z;
  logic vld, busy;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  cordic_vectoring_iterative dut (
    .clk_i(clk),
    .rst_i(rst),
    .x_i(x),
    .y_i(y),
    .data_in_valid_strobe_i(stb),
    .mag_o(mag),
    .z_o(z),
    .data_out_valid_strobe_o(vld),
    .busy_o(busy)
  );
  function automatic void ref_model(input logic signed [7:0] xi, input logic signed [7:0] yi, output int m, output int za);
    int atan_tbl[7] = '{128, 76, 40, 20, 10, 5, 3};
    int xx, yy, zz, t;
    if (xi >= 0) begin
      xx = 4 * xi; yy = 4 * yi; zz = 0;
    end else if (yi >= 0) begin
      xx = 4 * yi; yy = -4 * xi; zz = 256;
    end else begin
      xx = -4 * yi; yy = 4 * xi; zz = -256;
    end
    for (int i = 0; i < 7; i++) begin
      if (yy >= 0) begin
        t = xx + (yy >>> i); yy = yy - (xx >>> i); xx = t; zz = zz + atan_tbl[i];
      end else begin
        t = xx - (yy >>> i); yy = yy + (xx >>> i); xx = t; zz = zz - atan_tbl[i];
      end
    end
    m = ((xx + 2) >>> 2) & 511;
    za = ((zz + 2) >>> 2) & 255;
  endfunction
  task automatic do_op(input logic [7:0] xv, input logic [7:0] yv, output int lat, output int m, output int za, output int nstb, output int busy_bad);
    @(negedge clk);
    x = xv; y = yv; stb = 1'b1;
    lat = -1; m = -1; za = -1; nstb = 0; busy_bad = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      stb = 1'b0;
      if (vld) begin
        nstb++;
        if (lat < 0) begin lat = c; m = int'(mag); za = int'(z); end
      end
      if ((c <= 8) != busy) busy_bad++;
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks += 4;
    if (mag !== 9'd0) begin errors++; $display("FAIL reset_mag got %0d expected 0", mag); end
    if (z !== 8'd0) begin errors++; $display("FAIL reset_z got %0d expected 0", z); end
    if (vld !== 1'b0) begin errors++; $display("FAIL reset_strobe got %b expected 0", vld); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
    rst = 1'b0;
  endtask
  task automatic test_directed();
    int vx[7] = '{64, 0, 0, -64, -128, 0, 127};
    int vy[7] = '{0, 64, -64, 0, -128, 0, -128};
    int em[7] = '{105, 105, 105, 105, 298, 0, -1};
    int mt[7] = '{1, 1, 1, 1, 2, 0, 0};
    int ez[7] = '{0, 64, 192, 128, 160, 0, 0};
    int zt[7] = '{0, 1, 1, 1, 1, -1, -1};
    int lat, m, za, nstb, bb, rm, rz, dz, dm;
    for (int i = 0; i < 7; i++) begin
      ref_model(8'(vx[i]), 8'(vy[i]), rm, rz);
      do_op(8'(vx[i]), 8'(vy[i]), lat, m, za, nstb, bb);
      checks += 5;
      if (lat != 8) begin errors++; $display("FAIL dir%0d_latency got %0d expected 8", i, lat); end
      if (nstb != 1) begin errors++; $display("FAIL dir%0d_strobes got %0d expected 1", i, nstb); end
      if (bb != 0) begin errors++; $display("FAIL dir%0d_busy got %0d bad cycles expected 0", i, bb); end
      if (m != rm) begin errors++; $display("FAIL dir%0d_mag got %0d expected %0d", i, m, rm); end
      if (za != rz) begin errors++; $display("FAIL dir%0d_z got %0d expected %0d", i, za, rz); end
      if (em[i] >= 0) begin
        checks++;
        dm = m - em[i];
        if (dm > mt[i] || dm < -mt[i]) begin errors++; $display("FAIL dir%0d_mag_range got %0d expected %0d+-%0d", i, m, em[i], mt[i]); end
      end
      if (zt[i] >= 0) begin
        checks++;
        dz = (za - ez[i]) & 255;
        if (dz > 127) dz -= 256;
        if (dz > zt[i] || dz < -zt[i]) begin errors++; $display("FAIL dir%0d_z_range got %0d expected %0d+-%0d", i, za, ez[i], zt[i]); end
      end
    end
  endtask
  task automatic test_back_to_back();
    logic [7:0] xa = 8'($urandom), ya = 8'($urandom), xb = 8'($urandom), yb = 8'($urandom);
    logic [7:0] xc = 8'($urandom), yc = 8'($urandom), xd = 8'($urandom), yd = 8'($urandom);
    int ma, za, md, zd, n = 0, t1 = -1, t2 = -1, m1 = -1, z1 = -1, m2 = -1, z2 = -1;
    ref_model(xa, ya, ma, za);
    ref_model(xd, yd, md, zd);
    for (int c = 0; c <= 24; c++) begin
      @(negedge clk);
      if (vld) begin
        n++;
        if (n == 1) begin t1 = c; m1 = int'(mag); z1 = int'(z); end
        else if (n == 2) begin t2 = c; m2 = int'(mag); z2 = int'(z); end
      end
      stb = (c == 0 || c == 3 || c == 8 || c == 9);
      {x, y} = c == 0 ? {xa, ya} : c == 3 ? {xb, yb} : c == 8 ? {xc, yc} : {xd, yd};
    end
    checks += 7;
    if (n != 2) begin errors++; $display("FAIL b2b_strobes got %0d expected 2", n); end
    if (t1 != 8) begin errors++; $display("FAIL b2b_first_time got %0d expected 8", t1); end
    if (t2 != 17) begin errors++; $display("FAIL b2b_second_time got %0d expected 17", t2); end
    if (m1 != ma) begin errors++; $display("FAIL b2b_first_mag got %0d expected %0d", m1, ma); end
    if (z1 != za) begin errors++; $display("FAIL b2b_first_z got %0d expected %0d", z1, za); end
    if (m2 != md) begin errors++; $display("FAIL b2b_second_mag got %0d expected %0d", m2, md); end
    if (z2 != zd) begin errors++; $display("FAIL b2b_second_z got %0d expected %0d", z2, zd); end
  endtask
  task automatic test_reset_mid();
    int n = 0, nz = 0, lat, m, za, nstb, bb, rm, rz;
    logic busy3 = 1'b0;
    logic [8:0] mag_before;
    for (int c = 0; c <= 14; c++) begin
      @(negedge clk);
      if (c == 0) mag_before = mag;
      if (c == 3) busy3 = busy;
      if (vld) n++;
      if (c >= 5 && (mag !== 9'd0 || z !== 8'd0 || busy !== 1'b0)) nz++;
      stb = (c == 0);
      rst = (c == 4);
      x = 8'd100; y = 8'd50;
    end
    ref_model(8'd90, 8'hD0, rm, rz);
    do_op(8'd90, 8'hD0, lat, m, za, nstb, bb);
    checks += 6;
    if (mag_before == 9'd0) begin errors++; $display("FAIL rstmid_precondition got mag %0d expected nonzero", mag_before); end
    if (busy3 !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got %b expected 1", busy3); end
    if (n != 0) begin errors++; $display("FAIL rstmid_strobes got %0d expected 0", n); end
    if (nz != 0) begin errors++; $display("FAIL rstmid_outputs got %0d nonzero cycles expected 0", nz); end
    if (m != rm) begin errors++; $display("FAIL rstmid_after_mag got %0d expected %0d", m, rm); end
    if (za != rz || lat != 8) begin errors++; $display("FAIL rstmid_after_z got %0d at %0d expected %0d at 8", za, lat, rz); end
  endtask
  task automatic test_random();
    logic [7:0] xv, yv;
    int lat, m, za, nstb, bb, rm, rz, r;
    for (int i = 0; i < 1000; i++) begin
      r = $urandom_range(0, 9);
      xv = r == 0 ? 8'h80 : r == 1 ? 8'h7F : r == 2 ? 8'h00 : 8'($urandom);
      r = $urandom_range(0, 9);
      yv = r == 0 ? 8'h80 : r == 1 ? 8'h7F : r == 2 ? 8'h00 : 8'($urandom);
      ref_model(xv, yv, rm, rz);
      do_op(xv, yv, lat, m, za, nstb, bb);
      checks += 3;
      if (nstb != 1 || lat != 8) begin errors++; $display("FAIL rnd%0d_strobe got %0d strobes at %0d expected 1 at 8", i, nstb, lat); end
      if (m != rm) begin errors++; $display("FAIL rnd%0d_mag x=%0d y=%0d got %0d expected %0d", i, $signed(xv), $signed(yv), m, rm); end
      if (za != rz) begin errors++; $display("FAIL rnd%0d_z x=%0d y=%0d got %0d expected %0d", i, $signed(xv), $signed(yv), za, rz); end
    end
  endtask
  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
